ram_digit_writer: RTL

RAM_DIGIT_WRITER -- requirements
Module: ram_digit_writer

---
 rtl/ram_digit_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_digit_writer.sv
// Buffers single-cell digit writes and whole-screen fills into a text RAM, writing only during blanking.
// Latency: a popped request or fill step appears on the RAM port one cycle after the sampling edge.
// Backpressure: req_ready drops when the request FIFO is full or a fill is running; display_on=1 stalls all writes.
module ram_digit_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          display_on,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [4:0]                    req_row,
    input  logic [4:0]                    req_col,
    input  logic [3:0]                    req_digit,
    input  logic                          fill_start,
    input  logic [3:0]                    fill_digit,
    output logic                          ram_req,
    output logic [9:0]                    ram_addr,
    output logic [7:0]                    ram_din,
    output logic                          ram_we,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [9:0] LAST_ADDR = 10'd1023;

    typedef enum logic {IDLE, FILL} state_t;

    state_t         state;
    logic [13:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [9:0]     fill_addr;
    logic [3:0]     fill_val;
    logic           push;
    logic           pop;
    logic [13:0]    head;

    // Fills lock out new requests so the screen-wide write is never interleaved with cell writes.
    assign req_ready = (fifo_count < CW'(FIFO_DEPTH)) && (state != FILL);
    assign push      = req_valid && req_ready;
    // A fill request takes priority over draining the FIFO; queued entries wait until the fill ends.
    assign pop       = (state == IDLE) && !fill_start && (fifo_count != '0) && !display_on;
    assign head      = mem[rd_ptr];
    assign ram_we    = ram_req;

    // FIFO storage: entries are {row, col, digit} in arrival order; no reset needed on the data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_row, req_col, req_digit};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Control FSM with registered RAM port; the write strobe defaults low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fill_addr <= '0;
            fill_val  <= '0;
            ram_req   <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
        end else begin
            ram_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_val  <= fill_digit;
                        fill_addr <= '0;
                        state     <= FILL;
                        busy      <= 1'b1;
                    end else if (pop) begin
                        ram_req  <= 1'b1;
                        ram_addr <= head[13:4];
                        ram_din  <= {4'b0000, head[3:0]};
                    end
                end
                FILL: begin
                    // Pause on active video; the last address ends the fill without wrapping.
                    if (!display_on) begin
                        ram_req  <= 1'b1;
                        ram_addr <= fill_addr;
                        ram_din  <= {4'b0000, fill_val};
                        if (fill_addr == LAST_ADDR) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            fill_addr <= fill_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
